ram_port_arbiter: RTL and testbench

- Shares the single-port 32x8 RAM between two requesters (rq0, rq1) using round-robin arbitration.
- Accepts one read or write command at a time with a valid/ready handshake and drives the RAM's write_en/read_en/addr/data_in for exactly one cycle per command.
- Captures data_out after the RAM read latency and returns it to the requester that issued the read.
- Sits between the test/system requesters and the RAM.

---
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 552 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters (rq0, rq1).
// Optional: define RAM_ARB_FIXED_PRIO_EN so rq0 wins every tie (rq1 may then starve).
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_wr,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_wr,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              write_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic              owner;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        lat_cnt;
  logic              grant0;
  logic              grant1;
  logic              accept;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    grant0 = rq0_valid;
    grant1 = rq1_valid && !rq0_valid;
`else
    // On a tie the requester that was not served last time wins.
    grant0 = rq0_valid && (!rq1_valid || last_grant);
    grant1 = rq1_valid && (!rq0_valid || !last_grant);
`endif
  end

  assign accept = rq0_ready || rq1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CMD;
      CMD:     state_next = cmd_wr ? IDLE : WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    if (!rst && state == IDLE) begin
      rq0_ready = grant0;
      rq1_ready = grant1;
    end
    if (state == CMD) begin
      write_en = cmd_wr;
      read_en  = !cmd_wr;
    end
  end

  // addr/data_in come straight from the latched command so they hold between accesses.
  assign addr    = cmd_addr;
  assign data_in = cmd_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      lat_cnt    <= '0;
      rq0_rvalid <= 1'b0;
      rq1_rvalid <= 1'b0;
      rq0_rdata  <= '0;
      rq1_rdata  <= '0;
    end else begin
      rq0_rvalid <= 1'b0;
      rq1_rvalid <= 1'b0;
      if (accept) begin
        owner      <= rq1_ready;
        last_grant <= rq1_ready;
        cmd_wr     <= rq1_ready ? rq1_wr    : rq0_wr;
        cmd_addr   <= rq1_ready ? rq1_addr  : rq0_addr;
        cmd_wdata  <= rq1_ready ? rq1_wdata : rq0_wdata;
      end
      if (state == CMD)
        lat_cnt <= LAT_LOAD;
      else if (state == WAIT && lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 3'd1;
      if (state == RESP) begin
        if (owner) begin
          rq1_rvalid <= 1'b1;
          rq1_rdata  <= data_out;
        end else begin
          rq0_rvalid <= 1'b1;
          rq0_rdata  <= data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model; a second instance covers RD_LAT=3.
module tb_ram_port_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;

  logic          rq0_valid, rq0_wr, rq1_valid, rq1_wr;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [DW-1:0] rq0_wdata, rq1_wdata;
  logic          rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid;
  logic [DW-1:0] rq0_rdata, rq1_rdata;
  logic          write_en, read_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out = '0;

  logic          b_rq0_valid, b_rq0_wr, b_rq1_valid, b_rq1_wr;
  logic [AW-1:0] b_rq0_addr, b_rq1_addr;
  logic [DW-1:0] b_rq0_wdata, b_rq1_wdata;
  logic          b_rq0_ready, b_rq1_ready, b_rq0_rvalid, b_rq1_rvalid;
  logic [DW-1:0] b_rq0_rdata, b_rq1_rdata;
  logic          b_write_en, b_read_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data_in;
  logic [DW-1:0] b_data_out = '0;

  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] mem_a [0:31];
  logic [DW-1:0] mem_b [0:31];
  logic          mem_a_init = 1'b0;
  logic          mem_b_init = 1'b0;
  logic [1:0]    vpipe_b = '0;
  logic [DW-1:0] dpipe_b [0:1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .write_en(write_en), .read_en(read_en), .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .rq0_valid(b_rq0_valid), .rq0_ready(b_rq0_ready), .rq0_wr(b_rq0_wr), .rq0_addr(b_rq0_addr),
    .rq0_wdata(b_rq0_wdata), .rq0_rvalid(b_rq0_rvalid), .rq0_rdata(b_rq0_rdata),
    .rq1_valid(b_rq1_valid), .rq1_ready(b_rq1_ready), .rq1_wr(b_rq1_wr), .rq1_addr(b_rq1_addr),
    .rq1_wdata(b_rq1_wdata), .rq1_rvalid(b_rq1_rvalid), .rq1_rdata(b_rq1_rdata),
    .write_en(b_write_en), .read_en(b_read_en), .addr(b_addr), .data_in(b_data_in),
    .data_out(b_data_out)
  );

  // RAM for the RD_LAT=1 instance: registered read, output holds until the next read.
  always @(posedge clk) begin
    if (!mem_a_init) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= '0;
      mem_a_init <= 1'b1;
    end
    if (write_en) mem_a[addr] <= data_in;
    if (read_en)  data_out <= mem_a[addr];
  end

  // RAM for the RD_LAT=3 instance: output is junk until the third edge after read_en.
  always @(posedge clk) begin
    if (!mem_b_init) begin
      for (int i = 0; i < 32; i++) mem_b[i] <= '0;
      mem_b_init <= 1'b1;
    end
    if (b_write_en) mem_b[b_addr] <= b_data_in;
    vpipe_b    <= {vpipe_b[0], b_read_en};
    dpipe_b[0] <= mem_b[b_addr];
    dpipe_b[1] <= dpipe_b[0];
    if (b_read_en)  b_data_out <= 8'($urandom);
    if (vpipe_b[1]) b_data_out <= dpipe_b[1];
  end

  task automatic do_reset;
    rst = 1'b1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rq0_valid = 1'b1;
    rq1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rq0_ready, rq1_ready, write_en, read_en, rq0_rvalid, rq1_rvalid} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b exp 000000",
               {rq0_ready, rq1_ready, write_en, read_en, rq0_rvalid, rq1_rvalid});
    end
    checks++;
    if ({addr, data_in, rq0_rdata, rq1_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h exp 0", {addr, data_in, rq0_rdata, rq1_rdata});
    end
    checks++;
    if ({b_rq0_ready, b_rq1_ready, b_write_en, b_read_en, b_addr, b_data_in} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_b got %h exp 0",
               {b_rq0_ready, b_rq1_ready, b_write_en, b_read_en, b_addr, b_data_in});
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write_read;
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 5'd5; rq0_wdata = 8'hA5;
    @(negedge clk);
    checks++;
    if ({rq0_ready, rq1_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wr_ready got %b exp 10", {rq0_ready, rq1_ready});
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    ref_mem[5] = 8'hA5;
    @(negedge clk);
    checks++;
    if ({write_en, read_en, addr, data_in} !== {2'b10, 5'd5, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL wr_access got %b %b %0d %h exp 1 0 5 a5", write_en, read_en, addr, data_in);
    end
    @(posedge clk); #1;
    rq0_valid = 1'b1; rq0_wr = 1'b0; rq0_addr = 5'd5; rq0_wdata = 8'h00;
    @(negedge clk);
    checks++;
    if ({write_en, rq0_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wr_turnaround got %b exp 01", {write_en, rq0_ready});
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({read_en, write_en, addr} !== {2'b10, 5'd5}) begin
          errors++;
          $display("[TB] FAIL rd_access got %b %b %0d exp 1 0 5", read_en, write_en, addr);
        end
      end
      checks++;
      if ({rq0_rvalid, rq1_rvalid} !== {k == 3 + LAT_A, 1'b0}) begin
        errors++;
        $display("[TB] FAIL rd_rvalid k=%0d got %b exp %b", k, {rq0_rvalid, rq1_rvalid},
                 {k == 3 + LAT_A, 1'b0});
      end
      if (k == 3 + LAT_A) begin
        checks++;
        if (rq0_rdata !== 8'hA5) begin
          errors++;
          $display("[TB] FAIL rd_rdata got %h exp a5", rq0_rdata);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    logic [DW-1:0] d0 [4];
    logic [DW-1:0] d1 [4];
    int n0 = 0;
    int n1 = 0;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      d0[i] = 8'($urandom);
      d1[i] = 8'($urandom);
    end
    rst = 1'b1;
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 5'd0;  rq0_wdata = d0[0];
    rq1_valid = 1'b1; rq1_wr = 1'b1; rq1_addr = 5'd16; rq1_wdata = d1[0];
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      checks++;
      if ({rq0_ready, rq1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL cont_grant g=%0d got %b exp %b", g, {rq0_ready, rq1_ready},
                 (g % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1;
      if (g % 2 == 0) begin
        exp_a = 5'(n0); exp_d = d0[n0];
        n0++;
        if (n0 < 4) begin rq0_addr = 5'(n0); rq0_wdata = d0[n0]; end
        else rq0_valid = 1'b0;
      end else begin
        exp_a = 5'(16 + n1); exp_d = d1[n1];
        n1++;
        if (n1 < 4) begin rq1_addr = 5'(16 + n1); rq1_wdata = d1[n1]; end
        else rq1_valid = 1'b0;
      end
      ref_mem[exp_a] = exp_d;
      @(negedge clk);
      checks++;
      if ({write_en, read_en, rq0_ready, rq1_ready, addr, data_in} !== {4'b1000, exp_a, exp_d}) begin
        errors++;
        $display("[TB] FAIL cont_write g=%0d got %b %0d %h exp 1000 %0d %h", g,
                 {write_en, read_en, rq0_ready, rq1_ready}, addr, data_in, exp_a, exp_d);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({write_en, rq0_ready, rq1_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL cont_done got %b exp 000", {write_en, rq0_ready, rq1_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_routing;
    rq1_valid = 1'b1; rq1_wr = 1'b1; rq1_addr = 5'd16; rq1_wdata = 8'h3C;
    @(negedge clk);
    checks++;
    if (rq1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL route_prewrite got %b exp 1", rq1_ready);
    end
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    ref_mem[16] = 8'h3C;
    @(posedge clk); #1;
    rq1_valid = 1'b1; rq1_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({rq0_ready, rq1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL route_accept got %b exp 01", {rq0_ready, rq1_ready});
    end
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 5'd7; rq0_wdata = 8'h5A;
    for (int k = 1; k <= 3 + LAT_A; k++) begin
      @(negedge clk);
      checks++;
      if ({rq0_ready, rq1_rvalid, rq0_rvalid} !== {k == 3 + LAT_A, k == 3 + LAT_A, 1'b0}) begin
        errors++;
        $display("[TB] FAIL route_resp k=%0d got %b", k, {rq0_ready, rq1_rvalid, rq0_rvalid});
      end
      if (k == 3 + LAT_A) begin
        checks++;
        if (rq1_rdata !== 8'h3C) begin
          errors++;
          $display("[TB] FAIL route_rdata got %h exp 3c", rq1_rdata);
        end
      end
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    ref_mem[7] = 8'h5A;
    @(negedge clk);
    checks++;
    if ({write_en, addr, data_in} !== {1'b1, 5'd7, 8'h5A}) begin
      errors++;
      $display("[TB] FAIL route_after got %b %0d %h exp 1 7 5a", write_en, addr, data_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency3;
    b_rq1_valid = 1'b1; b_rq1_wr = 1'b1; b_rq1_addr = 5'd16; b_rq1_wdata = 8'h3C;
    @(negedge clk);
    @(posedge clk); #1;
    b_rq1_valid = 1'b0;
    @(posedge clk); #1;
    b_rq1_valid = 1'b1; b_rq1_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_rq0_ready, b_rq1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lat3_accept got %b exp 01", {b_rq0_ready, b_rq1_ready});
    end
    @(posedge clk); #1;
    b_rq1_valid = 1'b0;
    b_rq0_valid = 1'b1; b_rq0_wr = 1'b1; b_rq0_addr = 5'd7; b_rq0_wdata = 8'h5A;
    for (int k = 1; k <= 3 + LAT_B; k++) begin
      @(negedge clk);
      checks++;
      if ({b_rq0_ready, b_rq1_rvalid, b_rq0_rvalid} !== {k == 3 + LAT_B, k == 3 + LAT_B, 1'b0}) begin
        errors++;
        $display("[TB] FAIL lat3_resp k=%0d got %b", k, {b_rq0_ready, b_rq1_rvalid, b_rq0_rvalid});
      end
      if (k == 3 + LAT_B) begin
        checks++;
        if (b_rq1_rdata !== 8'h3C) begin
          errors++;
          $display("[TB] FAIL lat3_rdata got %h exp 3c", b_rq1_rdata);
        end
      end
    end
    @(posedge clk); #1;
    b_rq0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    logic seen = 1'b0;
    rq0_valid = 1'b1; rq0_wr = 1'b0; rq0_addr = 5'd16;
    @(negedge clk);
    checks++;
    if (rq0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_accept got %b exp 1", rq0_ready);
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (read_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_read_en got %b exp 1", read_en);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 5'd20; rq0_wdata = 8'h77;
    rq1_valid = 1'b1; rq1_wr = 1'b1; rq1_addr = 5'd21; rq1_wdata = 8'h88;
    #1;
    checks++;
    if ({rq0_ready, rq1_ready, write_en, read_en, rq0_rvalid, rq1_rvalid,
         addr, data_in, rq0_rdata, rq1_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got %b %b %h %h %h %h", {rq0_ready, rq1_ready, write_en, read_en},
               {rq0_rvalid, rq1_rvalid}, addr, data_in, rq0_rdata, rq1_rdata);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rq0_ready, rq1_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_tie got %b exp 10", {rq0_ready, rq1_ready});
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    ref_mem[20] = 8'h77;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | rq0_rvalid | rq1_rvalid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_no_rvalid got %b exp 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_withdraw;
    logic seen = 1'b0;
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 5'd9; rq0_wdata = 8'h99;
    @(negedge clk);
    checks++;
    if (rq0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_accept got %b exp 1", rq0_ready);
    end
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    ref_mem[9] = 8'h99;
    rq1_valid = 1'b1; rq1_wr = 1'b1; rq1_addr = 5'd9; rq1_wdata = 8'hEE;
    @(negedge clk);
    checks++;
    if ({write_en, rq1_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wd_cmd got %b exp 10", {write_en, rq1_ready});
    end
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | write_en | read_en | rq0_ready | rq1_ready;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_quiet got %b exp 0", seen);
    end
    @(posedge clk); #1;
    rq1_valid = 1'b1; rq1_wr = 1'b0; rq1_addr = 5'd9;
    @(negedge clk);
    checks++;
    if (rq1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_idle got %b exp 1", rq1_ready);
    end
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    for (int k = 1; k <= 3 + LAT_A; k++) begin
      @(negedge clk);
      checks++;
      if (rq1_rvalid !== (k == 3 + LAT_A)) begin
        errors++;
        $display("[TB] FAIL wd_rvalid k=%0d got %b", k, rq1_rvalid);
      end
    end
    checks++;
    if (rq1_rdata !== 8'h99) begin
      errors++;
      $display("[TB] FAIL wd_rdata got %h exp 99", rq1_rdata);
    end
    @(posedge clk); #1;
  endtask

  // Transaction-level model: an accepted command occupies the port for 2 cycles (write)
  // or 3+RD_LAT cycles (read); its RAM access follows one cycle after acceptance.
  task automatic test_random;
    bit            v [2];
    bit            cwr [2];
    logic [AW-1:0] caddr [2];
    logic [DW-1:0] cdata [2];
    int            idle_from = 0;
    int            model_last = 1;
    int            acc_t = -10;
    bit            acc_wr = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_data = '0;
    int            rv_t = -10;
    int            rv_owner = 0;
    logic [DW-1:0] rv_data = '0;
    bit            e0, e1, idle, acc_now;
    int            w;
    v[0] = 1'b0; v[1] = 1'b0;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] && $urandom_range(0, 2) != 0) begin
          v[r] = 1'b1;
          cwr[r] = 1'($urandom_range(0, 1));
          caddr[r] = 5'($urandom_range(0, 31));
          cdata[r] = 8'($urandom);
        end
      end
      rq0_valid = v[0]; rq0_wr = cwr[0]; rq0_addr = caddr[0]; rq0_wdata = cdata[0];
      rq1_valid = v[1]; rq1_wr = cwr[1]; rq1_addr = caddr[1]; rq1_wdata = cdata[1];
      @(negedge clk);
      idle = (t >= idle_from);
`ifdef RAM_ARB_FIXED_PRIO_EN
      e0 = idle && v[0];
      e1 = idle && v[1] && !v[0];
`else
      e0 = idle && v[0] && (!v[1] || model_last == 1);
      e1 = idle && v[1] && (!v[0] || model_last == 0);
`endif
      checks++;
      if ({rq0_ready, rq1_ready} !== {e0, e1}) begin
        errors++;
        $display("[TB] FAIL rnd_ready t=%0d got %b exp %b", t, {rq0_ready, rq1_ready}, {e0, e1});
      end
      acc_now = (acc_t + 1 == t);
      checks++;
      if ({write_en, read_en} !== {acc_now && acc_wr, acc_now && !acc_wr}) begin
        errors++;
        $display("[TB] FAIL rnd_enables t=%0d got %b exp %b", t, {write_en, read_en},
                 {acc_now && acc_wr, acc_now && !acc_wr});
      end
      if (acc_now) begin
        checks++;
        if ({addr, (acc_wr ? data_in : 8'h00)} !== {acc_addr, (acc_wr ? acc_data : 8'h00)}) begin
          errors++;
          $display("[TB] FAIL rnd_access t=%0d got %0d %h exp %0d %h", t, addr, data_in,
                   acc_addr, acc_data);
        end
      end
      checks++;
      if ({rq0_rvalid, rq1_rvalid} !== {rv_t == t && rv_owner == 0, rv_t == t && rv_owner == 1}) begin
        errors++;
        $display("[TB] FAIL rnd_rvalid t=%0d got %b", t, {rq0_rvalid, rq1_rvalid});
      end
      if (rv_t == t) begin
        checks++;
        if ((rv_owner == 1 ? rq1_rdata : rq0_rdata) !== rv_data) begin
          errors++;
          $display("[TB] FAIL rnd_rdata t=%0d owner=%0d got %h exp %h", t, rv_owner,
                   (rv_owner == 1 ? rq1_rdata : rq0_rdata), rv_data);
        end
      end
      if (e0 || e1) begin
        w = e1 ? 1 : 0;
        acc_t = t;
        acc_wr = cwr[w];
        acc_addr = caddr[w];
        acc_data = cdata[w];
        model_last = w;
        if (cwr[w]) begin
          ref_mem[caddr[w]] = cdata[w];
          idle_from = t + 2;
        end else begin
          rv_t = t + 3 + LAT_A;
          rv_owner = w;
          rv_data = ref_mem[caddr[w]];
          idle_from = t + 3 + LAT_A;
        end
        v[w] = 1'b0;
      end
      @(posedge clk); #1;
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    rq0_valid = 1'b0; rq0_wr = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 1'b0; rq1_wr = 1'b0; rq1_addr = '0; rq1_wdata = '0;
    b_rq0_valid = 1'b0; b_rq0_wr = 1'b0; b_rq0_addr = '0; b_rq0_wdata = '0;
    b_rq1_valid = 1'b0; b_rq1_wr = 1'b0; b_rq1_addr = '0; b_rq1_wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    $display("[TB] starting ram_port_arbiter bench");
    test_reset();
    test_write_read();
    test_contention();
    test_read_routing();
    test_latency3();
    test_reset_mid_read();
    test_withdraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
